// File: rtl/ws2811_pkg.sv
// Shared WS2811 definitions: FSM state encoding and 100 MHz link timing defaults.
// Used by the receive decoder and the PWM transmitter.
`timescale 1ns/1ps
package ws2811_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  // Line timing in 100 MHz clock cycles
  localparam int T0H       = 25;
  localparam int T1H       = 60;
  localparam int TBIT      = 125;
  localparam int RESET_GAP = 5000;

  localparam int BIT_THRESH_DEF = 42;
  localparam int MIN_HIGH_DEF   = 8;
  localparam int MAX_HIGH_DEF   = 100;
  localparam int CNT_W_DEF      = 13;
  localparam int FWD_SKIP_DEF   = 3;

endpackage

// File: rtl/ws2811_sync.sv
// Two-flop synchronizer for the asynchronous WS2811 line, followed by a registered
// edge detector. lvl_o lags the pin by 2 clk, rise_o/fall_o by 3 clk.
`timescale 1ns/1ps
module ws2811_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, lvl_q, prev_q, rise_q, fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= line_i;
      lvl_q  <= meta_q;
      prev_q <= lvl_q;
      rise_q <= lvl_q & ~prev_q;
      fall_q <= ~lvl_q & prev_q;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ws2811_decoder.sv
// WS2811 one-wire receiver: pulse-width bit decode, MSB-first byte assembly, latch gap detect.
// Optional pixel forwarding is compiled in with `define WS2811_FORWARD_EN.
`timescale 1ns/1ps
module ws2811_decoder
  import ws2811_pkg::*;
#(
`ifdef WS2811_FORWARD_EN
  parameter int FWD_SKIP   = FWD_SKIP_DEF,
`endif
  parameter int BIT_THRESH = BIT_THRESH_DEF,
  parameter int MIN_HIGH   = MIN_HIGH_DEF,
  parameter int MAX_HIGH   = MAX_HIGH_DEF,
  parameter int RESET_LOW  = RESET_GAP,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PWM_signal,
  output logic [7:0] saida_dados,
  output logic       valid,
  output logic       frame_end,
  output logic       bit_error,
  output logic       PWM_fwd
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HI_MIN   = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] HI_MAX   = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] HI_THR   = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(RESET_LOW - 1);

  logic             lvl, rise, fall;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [7:0]       shift_q, shift_d, data_q, data_d, byte_cnt_q, byte_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             valid_q, valid_d, frame_end_q, frame_end_d, bit_error_q, bit_error_d;
  logic [7:0]       shifted;
  logic             emit_ok;

  ws2811_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (PWM_signal),
    .lvl_o  (lvl),
    .rise_o (rise),
    .fall_o (fall)
  );

`ifdef WS2811_FORWARD_EN
  // The first FWD_SKIP bytes belong to this pixel; the rest of the frame is passed on.
  assign emit_ok = (byte_cnt_q < 8'(FWD_SKIP));
  assign PWM_fwd = lvl & ~emit_ok;
`else
  assign emit_ok = 1'b1;
  assign PWM_fwd = 1'b0;
`endif

  assign shifted = {shift_q[6:0], (hcnt_q >= HI_THR)};

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    lcnt_d      = lcnt_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_end_d = 1'b0;
    bit_error_d = 1'b0;

    case (state_q)
      S_SYNC: begin
        shift_d    = '0;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        if (lvl) begin
          lcnt_d = '0;
        end else if (lcnt_q == LOW_LAST) begin
          lcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          lcnt_d = lcnt_q + CNT_ONE;
        end
      end

      S_IDLE: begin
        if (rise) begin
          hcnt_d  = CNT_ONE;
          state_d = S_HIGH;
        end
      end

      S_HIGH: begin
        if (fall) begin
          if ((hcnt_q < HI_MIN) || (hcnt_q >= HI_MAX)) begin
            bit_error_d = 1'b1;
            state_d     = S_SYNC;
            lcnt_d      = '0;
            shift_d     = '0;
            bit_cnt_d   = '0;
            byte_cnt_d  = '0;
          end else begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
            lcnt_d    = CNT_ONE;
            state_d   = S_LOW;
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q != 8'hFF) byte_cnt_d = byte_cnt_q + 8'd1;
              if (emit_ok) begin
                valid_d = 1'b1;
                data_d  = shifted;
              end
            end
          end
        end else begin
          hcnt_d = (hcnt_q < HI_MAX) ? hcnt_q + CNT_ONE : hcnt_q;
          // A stuck-high line is rejected without waiting for the fall.
          if (hcnt_d >= HI_MAX) begin
            bit_error_d = 1'b1;
            state_d     = S_SYNC;
            lcnt_d      = '0;
            shift_d     = '0;
            bit_cnt_d   = '0;
            byte_cnt_d  = '0;
          end
        end
      end

      S_LOW: begin
        if (rise) begin
          hcnt_d  = CNT_ONE;
          state_d = S_HIGH;
        end else if (lcnt_q == LOW_LAST) begin
          frame_end_d = 1'b1;
          bit_error_d = (bit_cnt_q != 3'd0);
          lcnt_d      = '0;
          shift_d     = '0;
          bit_cnt_d   = '0;
          byte_cnt_d  = '0;
          state_d     = S_IDLE;
        end else begin
          lcnt_d = lcnt_q + CNT_ONE;
        end
      end

      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_SYNC;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_end_q <= 1'b0;
      bit_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_end_q <= frame_end_d;
      bit_error_q <= bit_error_d;
    end
  end

  assign saida_dados = data_q;
  assign valid       = valid_q;
  assign frame_end   = frame_end_q;
  assign bit_error   = bit_error_q;

endmodule
